luhn_nibble_framer: RTL and testbench
=====================================

# luhn_nibble_framer

Upstream framer for the Luhn mod-16 checker. Pops a byte-count header and payload bytes from two first-word-fall-through (FWFT) input FIFOs. Pushes a nibble count into the checker's size FIFO, then the payload nibbles, high nibble first, into its data FIFO. With the check-generation feature compiled in, it also computes and appends a Luhn mod-16 check nibble, so every emitted message is valid.

## Interface
No parameters.
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- len_empty  in  1  header FIFO empty
- read_len  out  1  header FIFO pop strobe
- num_bytes  in  7  header: payload byte count, valid while !len_empty
- byte_empty  in  1  payload FIFO empty
- read_byte  out  1  payload FIFO pop strobe
- data_byte  in  8  payload byte, valid while !byte_empty
- size_full  in  1  size FIFO full
- write_size  out  1  size FIFO push strobe
- num_nibbles  out  8  nibble count pushed with write_size
- data_full  in  1  data FIFO full
- write_nibble  out  1  data FIFO push strobe
- nibble  out  4  nibble pushed with write_nibble
- busy  out  1  high whenever state != IDLE

## Operation
- Registered state: state (IDLE, SIZE, HI, LO, CHK), bytes_left[6:0], total[7:0], remaining[7:0], accum[3:0].
- Strobes and num_nibbles/nibble are combinational from state, registers, FIFO flags and data_byte; no strobe is asserted without its flag permitting.
- IDLE, !len_empty:
  - read_len=1.
  - num_bytes==0: header discarded, stay IDLE, nothing emitted.
  - Otherwise: latch bytes_left=num_bytes, total=remaining=N, accum=0, go SIZE.
  - N = 2*num_bytes (+1 with check-generation feature).
- SIZE, !size_full: write_size=1, num_nibbles=total, go HI.
- HI, !byte_empty && !data_full:
  - write_nibble=1, nibble=data_byte[7:4], go LO.
  - The byte is not popped.
- LO, !byte_empty && !data_full:
  - write_nibble=1, nibble=data_byte[3:0], read_byte=1 (same cycle), bytes_left-=1.
  - Next state: bytes_left!=1 → HI; else CHK (feature on) or IDLE (feature off).
- CHK, !data_full: write_nibble=1, nibble=(16-accum) mod 16, go IDLE.
- Each payload nibble write, before decrementing remaining:
  - v = nibble if remaining is odd.
  - v = fold(2*nibble) if remaining is even, where fold(x) = x[4] + x[3:0], 4-bit.
  - accum = accum + v mod 16; remaining -= 1.
- Any stall (full/empty) holds state and all registers; no strobe that cycle.

## Timing
- Reset (async assert): state=IDLE, all counters 0. read_len, read_byte, write_size and write_nibble are 0, busy=0, num_nibbles=0, nibble=0.
- Deassert is synchronous to clock. Reset mid-message abandons the message silently; no partial size is re-sent.
- Latencies, unstalled:
  - Header pop → write_size: 1 cycle.
  - write_size → first nibble: 1 cycle.
- Throughput: one nibble per cycle.
- A B-byte message occupies 2 + 2B (+1) cycles, including the IDLE pop cycle.
- Back-to-back: the next header can pop on the cycle after the last nibble.
- Max message: 127 bytes → 254 nibbles, or 255 with the check nibble. The 8-bit count never overflows.

## Configuration
- LUHN_GEN_CHECK_EN defined:
  - CHK state exists.
  - N = 2B+1; the check nibble is appended, so the downstream Luhn sum is 0 mod 16.
- Undefined:
  - CHK is unreachable and removed.
  - N = 2B; accum logic is removed.
  - Payload passes through unmodified.

## Test plan
- Feature on, header 1, byte 0x12 → size 3; nibbles 1, 2, B; read_len and read_byte each pulse exactly once.
- Feature on, header 1, byte 0x88 → size 3; nibbles 8, 8, 7. Covers doubling with fold: 8 doubled is 16, folded to 1.
- Feature off, header 2, bytes 0xF0, 0x00 → size 4; nibbles F, 0, 0, 0; no CHK cycle.
- Header 0, then header 1 with 0x12 → zero header popped with no writes; the next message is emitted normally.
- Stall checks:
  - Hold data_full=1 for 5 cycles in HI, and byte_empty=1 for 3 cycles in LO.
  - Required: no strobes while stalled; nibble order and values unchanged.
- Reset mid-message:
  - Assert rst_n=0 mid-message, asynchronously, after the first nibble.
  - Required: strobes drop immediately, busy=0.
  - After release, the next header is framed correctly.

Source files
------------

// File: rtl/luhn_nibble_framer.sv
// luhn_nibble_framer
//   Pops a byte-count header and its payload bytes from two FWFT FIFOs and
//   pushes a nibble count into the checker's size FIFO, followed by the
//   payload nibbles (high nibble first) into its data FIFO.
//   Define LUHN_GEN_CHECK_EN to append a Luhn mod-16 check nibble, which makes
//   every emitted message sum to 0 mod 16 downstream.
//
// Ports
//   clock        rising-edge clock
//   rst_n        asynchronous active-low reset
//   len_empty    header FIFO empty       read_len     header FIFO pop
//   num_bytes    payload byte count (0 means discard header)
//   byte_empty   payload FIFO empty      read_byte    payload FIFO pop
//   data_byte    payload byte at the payload FIFO head
//   size_full    size FIFO full          write_size   size FIFO push
//   num_nibbles  nibble count pushed with write_size
//   data_full    data FIFO full          write_nibble data FIFO push
//   nibble       nibble pushed with write_nibble
//   busy         a message is in progress
//
// state | meaning
// IDLE  | waiting for a header; zero-length headers are popped and dropped
// SIZE  | pushing the nibble count
// HI    | pushing the high nibble of the head byte (byte stays in FIFO)
// LO    | pushing the low nibble and popping the byte
// CHK   | pushing the check nibble (LUHN_GEN_CHECK_EN only)

module luhn_nibble_framer (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       len_empty,
  output logic       read_len,
  input  logic [6:0] num_bytes,
  input  logic       byte_empty,
  output logic       read_byte,
  input  logic [7:0] data_byte,
  input  logic       size_full,
  output logic       write_size,
  output logic [7:0] num_nibbles,
  input  logic       data_full,
  output logic       write_nibble,
  output logic [3:0] nibble,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SIZE = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3
`ifdef LUHN_GEN_CHECK_EN
    ,
    CHK  = 3'd4
`endif
  } state_t;

  state_t     state;
  logic [6:0] bytes_left;
  logic [7:0] total;
  logic [7:0] n_init;

`ifdef LUHN_GEN_CHECK_EN
  logic [7:0] remaining;
  logic [3:0] accum;
  logic [4:0] dbl;
  logic [3:0] weighted;

  // One extra nibble for the appended check digit.
  assign n_init = {num_bytes, 1'b0} + 8'd1;

  // Nibbles an even distance from the end are doubled and folded
  // (hex digit sum of the 5-bit product), the rest pass unchanged.
  always_comb begin
    dbl      = {nibble, 1'b0};
    weighted = remaining[0] ? nibble : (dbl[3:0] + {3'b000, dbl[4]});
  end
`else
  assign n_init = {num_bytes, 1'b0};
`endif

  // Strobes are gated by rst_n so they drop the moment reset asserts,
  // even while a header is waiting in IDLE.
  always_comb begin
    read_len     = 1'b0;
    read_byte    = 1'b0;
    write_size   = 1'b0;
    write_nibble = 1'b0;
    num_nibbles  = 8'd0;
    nibble       = 4'd0;
    busy         = (state != IDLE);
    if (rst_n) begin
      case (state)
        IDLE: read_len = !len_empty;
        SIZE: begin
          if (!size_full) begin
            write_size  = 1'b1;
            num_nibbles = total;
          end
        end
        HI: begin
          if (!byte_empty && !data_full) begin
            write_nibble = 1'b1;
            nibble       = data_byte[7:4];
          end
        end
        LO: begin
          if (!byte_empty && !data_full) begin
            write_nibble = 1'b1;
            read_byte    = 1'b1;
            nibble       = data_byte[3:0];
          end
        end
`ifdef LUHN_GEN_CHECK_EN
        CHK: begin
          if (!data_full) begin
            write_nibble = 1'b1;
            nibble       = 4'd0 - accum;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bytes_left <= 7'd0;
      total      <= 8'd0;
`ifdef LUHN_GEN_CHECK_EN
      remaining  <= 8'd0;
      accum      <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!len_empty && (num_bytes != 7'd0)) begin
            bytes_left <= num_bytes;
            total      <= n_init;
`ifdef LUHN_GEN_CHECK_EN
            remaining  <= n_init;
            accum      <= 4'd0;
`endif
            state      <= SIZE;
          end
        end
        SIZE: if (!size_full) state <= HI;
        HI:   if (write_nibble) state <= LO;
        LO: begin
          if (write_nibble) begin
            bytes_left <= bytes_left - 7'd1;
            if (bytes_left != 7'd1) state <= HI;
`ifdef LUHN_GEN_CHECK_EN
            else                    state <= CHK;
`else
            else                    state <= IDLE;
`endif
          end
        end
`ifdef LUHN_GEN_CHECK_EN
        CHK: if (!data_full) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
`ifdef LUHN_GEN_CHECK_EN
      if (write_nibble && ((state == HI) || (state == LO))) begin
        accum     <= accum + weighted;
        remaining <= remaining - 8'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_luhn_nibble_framer.sv
// tb_luhn_nibble_framer
//   Directed bench for luhn_nibble_framer. Works with or without
//   LUHN_GEN_CHECK_EN; expectations follow the same macro.
//   The bench models both source FIFOs as queues and keeps an event-level
//   model of what must be pushed downstream (size, nibbles, check nibble),
//   compared every cycle, plus literal logs per directed test.

module tb_luhn_nibble_framer;

`ifdef LUHN_GEN_CHECK_EN
  localparam int CHKN = 1;
`else
  localparam int CHKN = 0;
`endif

  logic       clock = 1'b0;
  logic       rst_n;
  logic       len_empty, read_len, byte_empty, read_byte;
  logic       size_full, write_size, data_full, write_nibble, busy;
  logic [6:0] num_bytes;
  logic [7:0] data_byte, num_nibbles;
  logic [3:0] nibble;

  always #5 clock = ~clock;

  typedef struct packed {
    logic       is_size;
    logic       need_byte;
    logic       pop;
    logic [7:0] val;
  } ev_t;

  logic [6:0] hdr_q[$];
  logic [7:0] byt_q[$];
  ev_t        exp_q[$];
  int         obs_q[$];
  int         lit[$];
  logic       hold_sf, hold_df, hold_be;
  int         n_vec = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rl_cnt, rb_cnt, first_rl, last_wr;

  luhn_nibble_framer dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .len_empty   (len_empty),
    .read_len    (read_len),
    .num_bytes   (num_bytes),
    .byte_empty  (byte_empty),
    .read_byte   (read_byte),
    .data_byte   (data_byte),
    .size_full   (size_full),
    .write_size  (write_size),
    .num_nibbles (num_nibbles),
    .data_full   (data_full),
    .write_nibble(write_nibble),
    .nibble      (nibble),
    .busy        (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic refresh();
    len_empty  = (hdr_q.size() == 0);
    num_bytes  = len_empty ? 7'd0 : hdr_q[0];
    byte_empty = hold_be || (byt_q.size() == 0);
    data_byte  = (byt_q.size() == 0) ? 8'd0 : byt_q[0];
    size_full  = hold_sf;
    data_full  = hold_df;
  endtask

  // Expected downstream traffic for one message, taken straight from the
  // payload queue. Luhn weighting counts positions from the end of the
  // emitted message: last position undoubled, the one before doubled, etc.
  task automatic build(input int nb);
    int   n_tot;
    int   s;
    int   d;
    int   p;
    logic [7:0] b;
    ev_t  e;
    n_tot = 2 * nb + CHKN;
    s = 0;
    e = '{is_size: 1'b1, need_byte: 1'b0, pop: 1'b0, val: 8'(n_tot)};
    exp_q.push_back(e);
    for (int i = 0; i < 2 * nb; i++) begin
      b = byt_q[i / 2];
      d = (i % 2 == 0) ? int'(b[7:4]) : int'(b[3:0]);
      p = n_tot - i;
      if (p % 2 == 1) s += d;
      else            s += (2 * d > 15) ? (2 * d - 15) : (2 * d);
      e = '{is_size: 1'b0, need_byte: 1'b1, pop: (i % 2 == 1), val: 8'(d)};
      exp_q.push_back(e);
    end
    if (CHKN == 1) begin
      e = '{is_size: 1'b0, need_byte: 1'b0, pop: 1'b0, val: 8'((16 - s % 16) % 16)};
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_cycle();
    logic exp_busy, exp_ws, exp_wn;
    exp_busy = (exp_q.size() != 0);
    exp_ws   = 1'b0;
    exp_wn   = 1'b0;
    if (exp_busy) begin
      if (exp_q[0].is_size) exp_ws = !size_full;
      else exp_wn = !data_full && !(exp_q[0].need_byte && byte_empty);
    end
    chk("busy", busy, exp_busy);
    chk("read_len", read_len, !exp_busy && !len_empty);
    chk("write_size", write_size, exp_ws);
    chk("write_nibble", write_nibble, exp_wn);
    if (exp_ws) begin
      chk("num_nibbles", num_nibbles, exp_q[0].val);
      chk("read_byte_on_size", read_byte, 0);
      obs_q.push_back(256 + int'(num_nibbles));
      last_wr = cyc;
      void'(exp_q.pop_front());
    end else if (exp_wn) begin
      chk("nibble", nibble, exp_q[0].val);
      chk("read_byte", read_byte, exp_q[0].pop);
      obs_q.push_back(int'(nibble));
      last_wr = cyc;
      void'(exp_q.pop_front());
    end else begin
      chk("read_byte_idle", read_byte, 0);
    end
    if (read_byte) rb_cnt++;
    if (read_len) begin
      rl_cnt++;
      if (first_rl < 0) first_rl = cyc;
      if (num_bytes != 7'd0) build(int'(num_bytes));
    end
  endtask

  task automatic step();
    logic prl, prb;
    @(negedge clock);
    prl = read_len;
    prb = read_byte;
    if (rst_n) compare_cycle();
    @(posedge clock);
    #1;
    if (prl && hdr_q.size() != 0) void'(hdr_q.pop_front());
    if (prb && byt_q.size() != 0) void'(byt_q.pop_front());
    cyc++;
    refresh();
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300; k++) begin
      if (hdr_q.size() == 0 && exp_q.size() == 0 && !busy) break;
      step();
    end
    chk({name, "_drain"}, int'(hdr_q.size() != 0 || exp_q.size() != 0 || busy), 0);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    rl_cnt   = 0;
    rb_cnt   = 0;
    first_rl = -1;
    last_wr  = -1;
  endtask

  task automatic check_log(input string name);
    chk({name, "_log_len"}, obs_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < obs_q.size(); i++)
      chk({name, "_log"}, obs_q[i], lit[i]);
  endtask

  initial begin
    hold_sf = 1'b0;
    hold_df = 1'b0;
    hold_be = 1'b0;
    clear_obs();
    rst_n = 1'b1;
    // header queued during reset: read_len must stay low anyway
    hdr_q.push_back(7'd1);
    byt_q.push_back(8'h12);
    refresh();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_read_len", read_len, 0);
    chk("rst_read_byte", read_byte, 0);
    chk("rst_write_size", write_size, 0);
    chk("rst_write_nibble", write_nibble, 0);
    chk("rst_busy", busy, 0);
    chk("rst_num_nibbles", num_nibbles, 0);
    chk("rst_nibble", nibble, 0);
    step();
    step();
    rst_n = 1'b1;

    // T1: one byte 0x12
    drain("t1");
`ifdef LUHN_GEN_CHECK_EN
    lit = '{259, 1, 2, 11};
`else
    lit = '{258, 1, 2};
`endif
    check_log("t1");
    chk("t1_read_len_pulses", rl_cnt, 1);
    chk("t1_read_byte_pulses", rb_cnt, 1);
    chk("t1_span", last_wr - first_rl + 1, 4 + CHKN);

    // T2: one byte 0x88 (doubling with fold)
    clear_obs();
    hdr_q.push_back(7'd1);
    byt_q.push_back(8'h88);
    refresh();
    drain("t2");
`ifdef LUHN_GEN_CHECK_EN
    lit = '{259, 8, 8, 7};
`else
    lit = '{258, 8, 8};
`endif
    check_log("t2");
    chk("t2_span", last_wr - first_rl + 1, 4 + CHKN);

    // T3: two bytes 0xF0 0x00
    clear_obs();
    hdr_q.push_back(7'd2);
    byt_q.push_back(8'hF0);
    byt_q.push_back(8'h00);
    refresh();
    drain("t3");
`ifdef LUHN_GEN_CHECK_EN
    lit = '{261, 15, 0, 0, 0, 1};
`else
    lit = '{260, 15, 0, 0, 0};
`endif
    check_log("t3");
    chk("t3_span", last_wr - first_rl + 1, 6 + CHKN);

    // T4: zero header, then two back-to-back one-byte messages
    clear_obs();
    hdr_q.push_back(7'd0);
    hdr_q.push_back(7'd1);
    hdr_q.push_back(7'd1);
    byt_q.push_back(8'h12);
    byt_q.push_back(8'h88);
    refresh();
    drain("t4");
`ifdef LUHN_GEN_CHECK_EN
    lit = '{259, 1, 2, 11, 259, 8, 8, 7};
`else
    lit = '{258, 1, 2, 258, 8, 8};
`endif
    check_log("t4");
    chk("t4_read_len_pulses", rl_cnt, 3);
    chk("t4_read_byte_pulses", rb_cnt, 2);
    chk("t4_span", last_wr - first_rl + 1, 1 + 2 * (4 + CHKN));

    // T5: stalls in SIZE, HI and LO
    clear_obs();
    hdr_q.push_back(7'd2);
    byt_q.push_back(8'h3C);
    byt_q.push_back(8'h5A);
    refresh();
    step();
    hold_sf = 1'b1;
    refresh();
    repeat (2) step();
    hold_sf = 1'b0;
    refresh();
    step();
    hold_df = 1'b1;
    refresh();
    repeat (5) step();
    hold_df = 1'b0;
    refresh();
    step();
    hold_be = 1'b1;
    refresh();
    repeat (3) step();
    hold_be = 1'b0;
    refresh();
    drain("t5");
`ifdef LUHN_GEN_CHECK_EN
    lit = '{261, 3, 12, 5, 10, 10};
`else
    lit = '{260, 3, 12, 5, 10};
`endif
    check_log("t5");

    // T6: async reset after the first nibble, then a fresh message
    clear_obs();
    hdr_q.push_back(7'd2);
    byt_q.push_back(8'h77);
    byt_q.push_back(8'h66);
    refresh();
    repeat (3) step();
    hdr_q.push_back(7'd1);
    refresh();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_write_nibble", write_nibble, 0);
    chk("t6_rst_read_byte", read_byte, 0);
    chk("t6_rst_read_len", read_len, 0);
    chk("t6_rst_write_size", write_size, 0);
    chk("t6_rst_busy", busy, 0);
    exp_q.delete();
    byt_q.delete();
    byt_q.push_back(8'h12);
    refresh();
    clear_obs();
    repeat (2) step();
    rst_n = 1'b1;
    drain("t6");
`ifdef LUHN_GEN_CHECK_EN
    lit = '{259, 1, 2, 11};
`else
    lit = '{258, 1, 2};
`endif
    check_log("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
